// File: rtl/wb_uart_tx.sv
// Wishbone-attached UART transmitter: byte FIFO, programmable 16x baud divisor,
// 5..8 data bits, optional parity, one or two stop bits, level interrupt.
module wb_uart_tx #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [7:0]        wb_dat_i,
  output logic [7:0]        wb_dat_o,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              int_o,
  output logic              baud_o,
  output logic              stx_pad_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic              acc, wr, rd_status;
  logic              sel_txdata, sel_status, sel_ctrl, sel_divlo, sel_divhi;
  logic [7:0]        rdata;
  logic              unused_sel;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              fifo_empty, fifo_full;
  logic              push_req, push, pop, ovf_evt;
  logic              overflow;

  logic [6:0]        ctrl;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  bctr;
  logic              reload_pend;

  logic [2:0]        state;
  logic [3:0]        tcnt;
  logic [2:0]        bcnt;
  logic [7:0]        shreg;
  logic [1:0]        l_wlen;
  logic              l_par_en, l_par_bit, l_stop2;
  logic              tick, bit_end, can_start, tx_busy, last_data, stop_done;
  logic [7:0]        head, head_mask;
  logic              head_par;

  // Bus decode; register side effects happen on the registered ack cycle.
  assign acc        = wb_ack_o & wb_cyc_i & wb_stb_i;
  assign wr         = acc & wb_we_i & wb_sel_i[0];
  assign rd_status  = acc & ~wb_we_i & sel_status;
  assign sel_txdata = (wb_addr_i == ADDR_W'(0));
  assign sel_status = (wb_addr_i == ADDR_W'(1));
  assign sel_ctrl   = (wb_addr_i == ADDR_W'(2));
  assign sel_divlo  = (wb_addr_i == ADDR_W'(3));
  assign sel_divhi  = (wb_addr_i == ADDR_W'(4));
  assign unused_sel = ^wb_sel_i[3:1];

  always_ff @(posedge clk) begin
    if (wb_rst_i) wb_ack_o <= 1'b0;
    else          wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
  end

  always_comb begin
    rdata = '0;
    if (sel_status)      rdata = {4'b0000, overflow, tx_busy, fifo_full, fifo_empty};
    else if (sel_ctrl)   rdata = {1'b0, ctrl};
    else if (sel_divlo)  rdata = div[7:0];
    else if (sel_divhi)  rdata[DIV_W-9:0] = div[DIV_W-1:8];
  end

  assign wb_dat_o = (wb_ack_o & ~wb_we_i) ? rdata : '0;

  // FIFO: a write while full is dropped regardless of a same-cycle pop.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign push_req   = wr & sel_txdata;
  assign push       = push_req & ~fifo_full;
  assign ovf_evt    = push_req & fifo_full;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wb_dat_i;
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_evt)        overflow <= 1'b1;
      else if (rd_status) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      ctrl        <= 7'h03;
      div         <= DIV_W'(1);
      reload_pend <= 1'b0;
    end else begin
      if (wr && sel_ctrl)  ctrl <= wb_dat_i[6:0];
      if (wr && sel_divlo) div[7:0] <= wb_dat_i;
      if (wr && sel_divhi) div[DIV_W-1:8] <= wb_dat_i[DIV_W-9:0];
      reload_pend <= wr & (sel_divlo | sel_divhi);
    end
  end

  // Baud generator: one tick every D clocks; D=0 parks everything.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      bctr   <= DIV_W'(1);
      baud_o <= 1'b0;
    end else if (div == '0) begin
      bctr   <= '0;
      baud_o <= 1'b0;
    end else if (reload_pend) begin
      bctr   <= div;
      baud_o <= 1'b0;
    end else if (bctr <= DIV_W'(1)) begin
      bctr   <= div;
      baud_o <= 1'b1;
    end else begin
      bctr   <= bctr - DIV_W'(1);
      baud_o <= 1'b0;
    end
  end

  assign tick      = baud_o;
  assign bit_end   = tick & (tcnt == 4'hF);
  assign can_start = ctrl[5] & ~fifo_empty & (div != '0);
  assign last_data = (bcnt == ({1'b0, l_wlen} + 3'd4));
  assign stop_done = bit_end & (~l_stop2 | bcnt[0]);
  assign pop       = can_start & ((state == S_IDLE) | ((state == S_STOP) & stop_done));
  assign tx_busy   = (state != S_IDLE);
  assign int_o     = ctrl[6] & fifo_empty & ~tx_busy;

  // Parity is resolved at frame launch so later CTRL writes cannot alter it.
  assign head      = mem[rptr];
  assign head_mask = 8'hFF >> (2'd3 - ctrl[1:0]);
  assign head_par  = (^(head & head_mask)) ^ ~ctrl[3];

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      stx_pad_o <= 1'b1;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      l_wlen    <= '0;
      l_par_en  <= 1'b0;
      l_par_bit <= 1'b0;
      l_stop2   <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) tcnt <= tcnt + 4'd1;
      if (pop) begin
        state     <= S_START;
        stx_pad_o <= 1'b0;
        shreg     <= head;
        l_wlen    <= ctrl[1:0];
        l_par_en  <= ctrl[2];
        l_par_bit <= head_par;
        l_stop2   <= ctrl[4];
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_START:
            if (bit_end) begin
              state     <= S_DATA;
              stx_pad_o <= shreg[0];
              shreg     <= shreg >> 1;
              bcnt      <= '0;
            end
          S_DATA:
            if (bit_end) begin
              if (last_data) begin
                if (l_par_en) begin
                  state     <= S_PARITY;
                  stx_pad_o <= l_par_bit;
                end else begin
                  state     <= S_STOP;
                  stx_pad_o <= 1'b1;
                  bcnt      <= '0;
                end
              end else begin
                stx_pad_o <= shreg[0];
                shreg     <= shreg >> 1;
                bcnt      <= bcnt + 3'd1;
              end
            end
          S_PARITY:
            if (bit_end) begin
              state     <= S_STOP;
              stx_pad_o <= 1'b1;
              bcnt      <= '0;
            end
          S_STOP:
            if (bit_end) begin
              if (stop_done) state <= S_IDLE;
              else           bcnt  <= bcnt + 3'd1;
            end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboard bench for wb_uart_tx: expected reads and expected line frames are
// queued by the stimulus and consumed by independent bus and line monitors.
module tb_wb_uart_tx;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] addr;
  logic [3:0] sel;
  logic [7:0] dat_i, dat_o;
  logic       we, stb, cyc, ack, irq, baud, stx;

  always #5 clk = ~clk;

  wb_uart_tx #(.ADDR_W(5), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .wb_rst_i(rst), .wb_addr_i(addr), .wb_sel_i(sel),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack), .int_o(irq), .baud_o(baud), .stx_pad_o(stx)
  );

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  n;
    logic [15:0] clks;
    logic        b2b;
    logic [7:0]  id;
  } frame_t;

  int checks = 0, failures = 0;
  frame_t exp_q[$];
  logic [7:0] rd_q[$];
  logic [4:0] rd_a_q[$];
  int nexp = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Line levels in transmit order, e.g. "0 10100101 1"; spaces are ignored.
  function automatic frame_t mkframe(input string s, input int clks, input bit b2b, input int id);
    frame_t f;
    int n;
    f = '0;
    n = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == 8'h30 || s.getc(i) == 8'h31) begin
        f.bits[n] = (s.getc(i) == 8'h31);
        n++;
      end
    end
    f.n = 5'(n);
    f.clks = 16'(clks);
    f.b2b = b2b;
    f.id = 8'(id);
    return f;
  endfunction

  task automatic expect_frame(input string s, input int clks, input bit b2b, input int id);
    exp_q.push_back(mkframe(s, clks, b2b, id));
    nexp++;
  endtask

  task automatic bus(input logic w, input logic [4:0] a, input logic [7:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat_i = d; sel = s;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 4'h1);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    rd_a_q.push_back(a);
    bus(1'b0, a, 8'h00, 4'h1);
  endtask

  int frames_done = 0;
  task automatic wait_frames(input int target, input int budget);
    int t;
    t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < target) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
    end
  endtask

  // Read monitor.
  always @(negedge clk) begin
    logic [7:0] e;
    logic [4:0] a;
    if (!rst && ack && !we) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got data 0x%0h expected no ack", dat_o);
      end else begin
        e = rd_q.pop_front();
        a = rd_a_q.pop_front();
        check($sformatf("read_addr%0d", a), int'(dat_o), int'(e));
      end
    end
  end

  // Line monitor: counts baud ticks, 16 per bit, so divisor pauses are transparent.
  frame_t cur;
  int     cyc_n = 0, bit_i, tk, start_cyc, last_end = -100, bad_n;
  logic   mon_busy = 1'b0, last_smp;

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      mon_busy = 1'b0;
    end else if (baud) begin
      if (!mon_busy && stx == 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_start: got start bit at cycle %0d expected idle line", cyc_n);
          cur = mkframe("0", 0, 1'b0, 255);
        end else begin
          cur = exp_q.pop_front();
          if (cur.b2b) check($sformatf("f%0d_gap", cur.id), cyc_n - last_end - 1, 0);
        end
        mon_busy = 1'b1;
        bit_i = 0;
        tk = 0;
        bad_n = 0;
        start_cyc = cyc_n;
      end
      if (mon_busy) begin
        last_smp = stx;
        if (stx !== cur.bits[bit_i]) bad_n++;
        tk++;
        if (tk == 16) begin
          check($sformatf("f%0d_bit%0d_mismatched_ticks", cur.id, bit_i), bad_n, 0);
          tk = 0;
          bad_n = 0;
          bit_i++;
          if (bit_i == int'(cur.n)) begin
            mon_busy = 1'b0;
            last_end = cyc_n;
            frames_done++;
            if (cur.clks != 0) check($sformatf("f%0d_clks", cur.id), cyc_n - start_cyc + 1, int'(cur.clks));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bhi, chg;
    logic s0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; addr = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    check("rst_stx", int'(stx), 1);
    check("rst_ack", int'(ack), 0);
    check("rst_dat", int'(dat_o), 0);
    check("rst_baud", int'(baud), 0);
    check("rst_int", int'(irq), 0);
    rst = 1'b0;

    // Register reset values and map.
    rd(5'd1, 8'h01);
    rd(5'd2, 8'h03);
    rd(5'd3, 8'h01);
    rd(5'd4, 8'h00);
    rd(5'd0, 8'h00);
    rd(5'd7, 8'h00);
    wr(5'd2, 8'hFF);
    rd(5'd2, 8'h7F);
    check("int_idle_empty", int'(irq), 1);
    bus(1'b1, 5'd2, 8'h00, 4'hE);
    rd(5'd2, 8'h7F);
    wr(5'd2, 8'h03);
    check("int_disabled", int'(irq), 0);
    wr(5'd4, 8'hAB);
    rd(5'd4, 8'hAB);
    wr(5'd4, 8'h00);
    rd(5'd4, 8'h00);

    // 8N1 0xA5.
    wr(5'd2, 8'h23);
    expect_frame("0 10100101 1", 160, 1'b0, 1);
    wr(5'd0, 8'hA5);
    repeat (20) @(negedge clk);
    rd(5'd1, 8'h05);
    wait_frames(nexp, 400);

    // 5 data bits, odd parity, 0x16.
    wr(5'd2, 8'h24);
    expect_frame("0 01101 0 1", 128, 1'b0, 2);
    wr(5'd0, 8'h16);
    wait_frames(nexp, 400);

    // 7E2: 0x03 then 0x07 queued behind it.
    wr(5'd2, 8'h3E);
    expect_frame("0 1100000 0 11", 176, 1'b0, 3);
    expect_frame("0 1110000 1 11", 176, 1'b1, 4);
    wr(5'd0, 8'h03);
    wr(5'd0, 8'h07);
    wait_frames(nexp, 800);

    // Three queued bytes, back-to-back, interrupt at the end.
    wr(5'd2, 8'h03);
    wr(5'd0, 8'h00);
    wr(5'd0, 8'hFF);
    wr(5'd0, 8'h3C);
    rd(5'd1, 8'h00);
    expect_frame("0 00000000 1", 160, 1'b0, 5);
    expect_frame("0 11111111 1", 160, 1'b1, 6);
    expect_frame("0 00111100 1", 160, 1'b1, 7);
    wr(5'd2, 8'h63);
    repeat (100) @(negedge clk);
    check("int_while_busy", int'(irq), 0);
    wait_frames(nexp, 1200);
    repeat (2) @(negedge clk);
    check("int_after_frames", int'(irq), 1);
    rd(5'd1, 8'h01);

    // Divisor 0 mid-frame freezes ticks and the line, D=1 resumes.
    wr(5'd2, 8'h23);
    expect_frame("0 11110000 1", 0, 1'b0, 8);
    wr(5'd0, 8'h0F);
    repeat (40) @(negedge clk);
    wr(5'd3, 8'h00);
    repeat (3) @(negedge clk);
    s0 = stx;
    bhi = 0;
    chg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (baud) bhi++;
      if (stx !== s0) chg++;
    end
    check("pause_baud_ticks", bhi, 0);
    check("pause_line_changes", chg, 0);
    rd(5'd1, 8'h05);
    wr(5'd3, 8'h01);
    wait_frames(nexp, 600);

    // Overflow with transmitter disabled.
    wr(5'd2, 8'h03);
    for (int i = 0; i <= int'(DEPTH); i++) wr(5'd0, 8'h55);
    rd(5'd1, 8'h0A);
    rd(5'd1, 8'h02);

    // Reset while a frame is in DATA.
    exp_q.push_back(mkframe("0 10101010 1", 0, 1'b0, 9));
    wr(5'd2, 8'h23);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midframe_rst_stx", int'(stx), 1);
    @(negedge clk);
    rst = 1'b0;
    check("frames_left", exp_q.size(), 0);
    rd(5'd1, 8'h01);
    rd(5'd2, 8'h03);
    repeat (40) @(negedge clk);
    check("line_idle_after_rst", int'(stx), 1);

    repeat (4) @(negedge clk);
    check("reads_pending", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 The module SHALL have the parameter ADDR_W, default 5, meaning the Wishbone byte-address width.
REQ-002 The module SHALL have the parameter FIFO_DEPTH, default 16, meaning TX FIFO entries (power of two, 2..256).
REQ-003 The module SHALL have the parameter DIV_W, default 16, meaning the baud divisor width (9..16).
REQ-004 The module SHALL have one clock and a synchronous, active-high reset.
REQ-005 The module SHALL have these ports, one per line:
- clk  in  1  single clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_addr_i  in  ADDR_W  register byte address
- wb_sel_i  in  4  byte select; bit 0 gates writes, other bits ignored
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- int_o  out  1  interrupt, level
- baud_o  out  1  16x baud tick, one clk wide
- stx_pad_o  out  1  serial TX line, idle high

Function
REQ-006 The block SHALL use this register map:
- 0 TXDATA: write-only; a write pushes into the FIFO.
- 1 STATUS: read-only; [0] fifo_empty, [1] fifo_full, [2] tx_busy, [3] overflow (sticky).
- 2 CTRL: read/write; [1:0] wlen (00=5 ... 11=8 bits), [2] par_en, [3] par_even, [4] stop2, [5] tx_en, [6] int_en.
- 3 DIV_LO: read/write; divisor bits [7:0].
- 4 DIV_HI: read/write; divisor bits [DIV_W-1:8], with unused bits reading 0.
- Any other address reads 0, and writes to it are ignored.
REQ-007 wb_ack_o SHALL be registered: ack <= cyc & stb & !ack, giving 1-cycle latency and at most one ack per two clocks.
REQ-008 Register writes SHALL take effect on the ack cycle, only when wb_we_i=1 and wb_sel_i[0]=1.
REQ-009 wb_dat_o SHALL be valid on the ack cycle and 0 otherwise.
REQ-010 A STATUS read SHALL clear overflow on its ack cycle; if an overflow event occurs in the same cycle, overflow SHALL stay set.
REQ-011 A TXDATA write when fifo_full=1 SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-012 A TXDATA write when the FIFO is not full SHALL push; simultaneous push and pop SHALL leave the count unchanged.
REQ-013 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 The baud counter SHALL load the divisor D, decrement each clk, and pulse baud_o for one clk when reaching 1, then reload.
REQ-015 D=0 SHALL stop ticks, with baud_o=0 and the TX FSM frozen in place.
REQ-016 A divisor write SHALL reload the counter on the following clk.
REQ-017 The TX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, each bit lasting 16 baud ticks.
REQ-018 IDLE -> START SHALL occur when tx_en=1 and the FIFO is not empty. On that transition the FSM SHALL pop one entry and latch the entry, wlen, par_en, par_even and stop2. CTRL changes mid-frame SHALL NOT affect the current frame.
REQ-019 DATA SHALL shift LSB first for wlen+5 bits, then go to PARITY if par_en=1, else STOP.
REQ-020 The parity bit SHALL make the count of ones (data plus parity) even when par_even=1, and odd otherwise.
REQ-021 STOP SHALL drive 1 for one bit, or two bits if stop2=1.
REQ-022 From STOP, the FSM SHALL go to START directly if tx_en=1 and the FIFO is not empty (no idle gap); otherwise it SHALL go to IDLE.
REQ-023 Clearing tx_en SHALL complete the current frame; no new frame SHALL start while tx_en=0.
REQ-024 tx_busy SHALL equal 1 in every state except IDLE.
REQ-025 int_o SHALL equal int_en & fifo_empty & !tx_busy.

Reset
REQ-026 While wb_rst_i=1 on a clk edge, all registers SHALL reset to these values:
- FIFO empty
- overflow=0
- CTRL=0x03 (8N1, tx_en=0, int_en=0)
- divisor=1
- FSM in IDLE
- stx_pad_o=1
- wb_ack_o=0
- wb_dat_o=0
- baud_o=0
- int_o=0
REQ-027 Reset asserted mid-frame SHALL abort the frame, drive stx_pad_o=1 on the next clk, and discard FIFO contents.

Verification
REQ-028 8N1 frame: D=1, CTRL=0x23, write 0xA5 -> stx_pad_o shows 0, 1,0,1,0,0,1,0,1, 1, each level held 16 clks, and the frame lasts 160 clks.
REQ-029 7E2 frame: CTRL=0x3E, write 0x03 -> 7 data bits 1100000, parity 0, two stop bits; a second write of 0x07 -> parity 1.
REQ-030 Overflow: tx_en=0 with FIFO_DEPTH+1 writes -> STATUS=0x0A. A second STATUS read -> 0x02.
REQ-031 Back-to-back: 3 queued bytes with tx_en=1 -> no idle high between the stop bit and the next start bit. After the last frame, int_o=1 if int_en=1.
REQ-032 Divisor 0 mid-frame: write DIV_LO=0 -> baud_o=0 and stx_pad_o holds its level. Writing D=1 -> the frame resumes.
REQ-033 Reset mid-DATA -> stx_pad_o=1 on the next clk and STATUS=0x01.
